// File: rtl/serial_arith_pkg.sv
// Shared constants for the bit-serial arithmetic units: FSM state encoding and default width.
package serial_arith_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } serial_state_e;

    localparam int unsigned SERIAL_WIDTH_DEF = 8;

endpackage

// File: rtl/half_sub.sv
// Combinational half subtractor: d = x - y (one bit), bo = borrow out.
module half_sub (
    input  logic x_i,
    input  logic y_i,
    output logic d_o,
    output logic bo_o
);

    assign d_o  = x_i ^ y_i;
    assign bo_o = ~x_i & y_i;

endmodule

// File: rtl/serial_sub.sv
// Bit-serial WIDTH-bit subtractor (diff = a - b, LSB first) behind a start/done handshake.
// Optional signed-overflow output enabled by defining SERIAL_SUB_OVF_EN.
module serial_sub
    import serial_arith_pkg::*;
#(
    parameter int unsigned WIDTH = SERIAL_WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] diff_o,
    output logic             borrow_out_o
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             ovf_o
`endif
);

    localparam int unsigned CntW = $clog2(WIDTH);

    serial_state_e    state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] res_sh_q, res_sh_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             borrow_q, borrow_d;
    logic             borrow_out_q, borrow_out_d;
    logic             bit_d, bo1, bo2, d1, bnext;

    // Full-subtract cell: two half subtractors plus an OR on their borrows.
    half_sub u_hs_ab (
        .x_i  (a_sh_q[0]),
        .y_i  (b_sh_q[0]),
        .d_o  (d1),
        .bo_o (bo1)
    );

    half_sub u_hs_bw (
        .x_i  (d1),
        .y_i  (borrow_q),
        .d_o  (bit_d),
        .bo_o (bo2)
    );

    assign bnext = bo1 | bo2;

`ifdef SERIAL_SUB_OVF_EN
    logic ovf_q, ovf_d;
    // On the last bit a_sh[0]/b_sh[0] are the operand MSBs and bit_d is the result MSB.
    assign ovf_d = (state_q == ST_SHIFT && cnt_q == CntW'(WIDTH - 1)) ?
                   ((a_sh_q[0] ^ b_sh_q[0]) & (bit_d ^ a_sh_q[0])) : ovf_q;
`endif

    always_comb begin
        state_d      = state_q;
        a_sh_d       = a_sh_q;
        b_sh_d       = b_sh_q;
        res_sh_d     = res_sh_q;
        diff_d       = diff_q;
        cnt_d        = cnt_q;
        borrow_d     = borrow_q;
        borrow_out_d = borrow_out_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    a_sh_d   = a_i;
                    b_sh_d   = b_i;
                    res_sh_d = '0;
                    cnt_d    = '0;
                    borrow_d = 1'b0;
                    state_d  = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                a_sh_d   = a_sh_q >> 1;
                b_sh_d   = b_sh_q >> 1;
                res_sh_d = {bit_d, res_sh_q[WIDTH-1:1]};
                borrow_d = bnext;
                cnt_d    = cnt_q + CntW'(1);
                if (cnt_q == CntW'(WIDTH - 1)) begin
                    diff_d       = {bit_d, res_sh_q[WIDTH-1:1]};
                    borrow_out_d = bnext;
                    state_d      = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            a_sh_q       <= '0;
            b_sh_q       <= '0;
            res_sh_q     <= '0;
            diff_q       <= '0;
            cnt_q        <= '0;
            borrow_q     <= 1'b0;
            borrow_out_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            a_sh_q       <= a_sh_d;
            b_sh_q       <= b_sh_d;
            res_sh_q     <= res_sh_d;
            diff_q       <= diff_d;
            cnt_q        <= cnt_d;
            borrow_q     <= borrow_d;
            borrow_out_q <= borrow_out_d;
        end
    end

`ifdef SERIAL_SUB_OVF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf_o = ovf_q;
`endif

    assign busy_o       = (state_q == ST_SHIFT);
    assign done_o       = (state_q == ST_DONE);
    assign diff_o       = diff_q;
    assign borrow_out_o = borrow_out_q;

endmodule

// File: tb/tb_serial_sub.sv
// Self-checking bench for serial_sub: timeline/arithmetic model plus directed literal checks.
module tb_serial_sub;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         start_i;
    logic [W-1:0] a_i;
    logic [W-1:0] b_i;
    logic         busy_o;
    logic         done_o;
    logic [W-1:0] diff_o;
    logic         borrow_out_o;
`ifdef SERIAL_SUB_OVF_EN
    logic         ovf_o;
`endif

    int checks = 0;
    int errors = 0;

    serial_sub #(.WIDTH(W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start_i      (start_i),
        .a_i          (a_i),
        .b_i          (b_i),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .diff_o       (diff_o),
        .borrow_out_o (borrow_out_o)
`ifdef SERIAL_SUB_OVF_EN
        ,
        .ovf_o        (ovf_o)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: an accepted start at edge k yields busy after edges k..k+W-1, done after
    // edge k+W, and the next accept no earlier than edge k+W+2.
    int           cyc;
    int           acc;
    bit           have_acc;
    logic [W-1:0] pend_diff, exp_diff;
    logic         pend_bo, exp_bo;
    logic         pend_ovf, exp_ovf;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc      <= 0;
            acc      <= 0;
            have_acc <= 1'b0;
            exp_diff <= '0;
            exp_bo   <= 1'b0;
            exp_ovf  <= 1'b0;
        end else begin
            cyc <= cyc + 1;
            if (have_acc && cyc == acc + W) begin
                exp_diff <= pend_diff;
                exp_bo   <= pend_bo;
                exp_ovf  <= pend_ovf;
            end
            if (start_i && (!have_acc || cyc >= acc + W + 2)) begin
                have_acc  <= 1'b1;
                acc       <= cyc;
                pend_diff <= a_i - b_i;
                pend_bo   <= (a_i < b_i);
                pend_ovf  <= (a_i[W-1] != b_i[W-1]) && (((a_i - b_i) >> (W - 1)) != W'(a_i[W-1]));
            end
        end
    end

    always @(negedge clk) begin
        logic eb, ed;
        eb = have_acc && (cyc >= acc + 1) && (cyc <= acc + W);
        ed = have_acc && (cyc == acc + W + 1);
        check("busy", int'(busy_o), int'(eb));
        check("done", int'(done_o), int'(ed));
        check("diff", int'(diff_o), int'(exp_diff));
        check("borrow_out", int'(borrow_out_o), int'(exp_bo));
`ifdef SERIAL_SUB_OVF_EN
        check("ovf", int'(ovf_o), int'(exp_ovf));
`endif
    end

    // Launch one operation and wait for done; n counts negedges after the accepting edge.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          output int lat, output int busy_cnt);
        int n;
        @(negedge clk);
        start_i = 1'b1;
        a_i     = a;
        b_i     = b;
        n        = 0;
        busy_cnt = 0;
        lat      = -1;
        while (n < 40 && lat < 0) begin
            @(negedge clk);
            start_i = 1'b0;
            n++;
            if (busy_o) busy_cnt++;
            if (done_o) lat = n;
        end
        if (lat < 0) check("done_timeout", 0, 1);
    endtask

    initial begin
        int lat, bc, n, first_n, second_n;
        rst_n   = 1'b0;
        start_i = 1'b0;
        a_i     = '0;
        b_i     = '0;
        #12;
        check("rst_busy", int'(busy_o), 0);
        check("rst_done", int'(done_o), 0);
        check("rst_diff", int'(diff_o), 0);
        check("rst_borrow", int'(borrow_out_o), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        run_op(8'd5, 8'd3, lat, bc);
        check("t1_latency", lat, 9);
        check("t1_busy_cycles", bc, 8);
        check("t1_diff", int'(diff_o), 2);
        check("t1_borrow", int'(borrow_out_o), 0);

        run_op(8'd3, 8'd5, lat, bc);
        check("t2_diff", int'(diff_o), 254);
        check("t2_borrow", int'(borrow_out_o), 1);
`ifdef SERIAL_SUB_OVF_EN
        check("t2_ovf", int'(ovf_o), 0);
`endif

        run_op(8'h80, 8'h01, lat, bc);
        check("t3_diff", int'(diff_o), 8'h7F);
        check("t3_borrow", int'(borrow_out_o), 0);
`ifdef SERIAL_SUB_OVF_EN
        check("t3_ovf", int'(ovf_o), 1);
`endif

        // Back-to-back at the earliest accept; run_op returns on the done negedge.
        run_op(8'd255, 8'd255, lat, bc);
        check("t4a_diff", int'(diff_o), 0);
        check("t4a_borrow", int'(borrow_out_o), 0);
        run_op(8'd0, 8'd0, lat, bc);
        check("t4b_latency", lat, 9);
        check("t4b_diff", int'(diff_o), 0);
        check("t4b_borrow", int'(borrow_out_o), 0);

        // start held through busy and DONE; operands change mid-op.
        @(negedge clk);
        start_i  = 1'b1;
        a_i      = 8'd9;
        b_i      = 8'd4;
        n        = 0;
        first_n  = -1;
        second_n = -1;
        while (n < 40 && second_n < 0) begin
            @(negedge clk);
            n++;
            if (n == 3) begin
                a_i = 8'd20;
                b_i = 8'd6;
            end
            if (n == 11) start_i = 1'b0;
            if (done_o) begin
                if (first_n < 0) begin
                    first_n = n;
                    check("t5_first_diff", int'(diff_o), 5);
                end else begin
                    second_n = n;
                    check("t5_second_diff", int'(diff_o), 14);
                end
            end
        end
        check("t5_first_latency", first_n, 9);
        check("t5_second_latency", second_n, 19);
        start_i = 1'b0;

        // Reset on the 4th SHIFT cycle.
        @(negedge clk);
        start_i = 1'b1;
        a_i     = 8'd200;
        b_i     = 8'd1;
        repeat (4) begin
            @(negedge clk);
            start_i = 1'b0;
        end
        check("t6_busy_before", int'(busy_o), 1);
        #2 rst_n = 1'b0;
        #1;
        check("t6_busy", int'(busy_o), 0);
        check("t6_done", int'(done_o), 0);
        check("t6_diff", int'(diff_o), 0);
        check("t6_borrow", int'(borrow_out_o), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        repeat (12) begin
            @(negedge clk);
            if (done_o) n++;
        end
        check("t6_no_done", n, 0);
        run_op(8'd10, 8'd7, lat, bc);
        check("t6_new_diff", int'(diff_o), 3);
        check("t6_new_borrow", int'(borrow_out_o), 0);

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_sub.md
Name: serial_sub

Overview:
- Bit-serial N-bit subtractor computing diff = a - b, one bit per clock, LSB first.
- It is the subtract-direction counterpart of the team's half-adder cell: the borrow chain is held in a single flip-flop instead of a ripple.
- Used as an area-minimal arithmetic unit behind a start/done handshake in the small-datapath blocks.

Parameters:
- WIDTH, 8, operand and result width in bits (WIDTH >= 2).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request to begin a subtraction. Sampled only in IDLE.
- a  input  WIDTH  minuend. Captured on the accepting edge.
- b  input  WIDTH  subtrahend. Captured on the accepting edge.
- busy  output  1  high while the operation is in progress (SHIFT state).
- done  output  1  one-cycle pulse; diff and borrow_out are valid.
- diff  output  WIDTH  a - b modulo 2^WIDTH.
- borrow_out  output  1  final borrow; 1 iff unsigned a < b.

Behaviour:
- Clock and reset (already decided): one clock, clk; reset is asynchronous and active-low, rst_n.
- Reset values: state=IDLE, busy=0, done=0, diff=0, borrow_out=0. Internal operand shift registers, counter and borrow flop are all 0.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - start=1 at edge E0 loads a_sh<=a, b_sh<=b, bit counter cnt<=0 and borrow<=0, then goes to SHIFT.
  - start=0 stays in IDLE.
- SHIFT, each edge:
  - d = a_sh[0] ^ b_sh[0] ^ borrow.
  - bnext = (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & borrow).
  - The result shift register takes d into the MSB and shifts right. a_sh and b_sh shift right. borrow<=bnext. cnt<=cnt+1.
  - When cnt == WIDTH-1: on that edge, diff<=final result, borrow_out<=bnext, and state goes to DONE.
- DONE: done=1 for exactly one cycle, then returns to IDLE unconditionally. start is ignored in DONE.
- Latency: start accepted at E0 → busy=1 for cycles after E0 .. E0+WIDTH-1 → done=1 in the cycle after edge E0+WIDTH. Next start is accepted at edge E0+WIDTH+2 at the earliest.
- diff and borrow_out hold their values until the next completion. They do not change during SHIFT.
- start asserted while busy or in DONE: ignored, with no queuing. The a/b inputs are don't-care outside the accepting edge.
- Reset asserted mid-operation: all state and outputs clear immediately (async). The aborted result is never reported and done does not pulse.
- cnt width: $clog2(WIDTH) bits. It wraps only via reload.

Optional Feature:
- Macro: SERIAL_SUB_OVF_EN.
- Defined: adds output port ovf (1 bit, reset 0), the signed two's-complement overflow flag. It is set when a[MSB] != b[MSB] and diff[MSB] != a[MSB]. It is latched with diff at completion and held until the next completion.
- Undefined: no ovf port and no MSB-tracking logic. Behaviour is otherwise identical.

Decomposition:
- Shared package serial_arith_pkg holds:
  - the state enum constants ST_IDLE=2'd0, ST_SHIFT=2'd1, ST_DONE=2'd2;
  - the default width constant SERIAL_WIDTH_DEF=8.
- One natural sub-module: half_sub (inputs x, y; outputs d, bo). Two instances plus an OR form the per-bit full-subtract cell; it is combinational.
- FSM, shift registers and counter stay in serial_sub.

Test Plan:
- Reset, then start with a=5, b=3 → done pulses 9 cycles after the accepting edge; diff=2, borrow_out=0; busy high for exactly 8 cycles.
- a=3, b=5 → diff=254 (0xFE), borrow_out=1. With SERIAL_SUB_OVF_EN: ovf=0.
- a=0x80, b=0x01 → diff=0x7F, borrow_out=0. With SERIAL_SUB_OVF_EN: ovf=1.
- a=255, b=255 then a=0, b=0, back-to-back at the earliest accept → both give diff=0, borrow_out=0; exactly two done pulses.
- start held high with a=9, b=4 throughout busy and DONE → a single result diff=5; the second start is accepted only on returning to IDLE; a/b changed mid-op have no effect.
- Deassert rst_n on the 4th SHIFT cycle → outputs go to 0 immediately, no done pulse; a new start with a=10, b=7 after release → diff=3.
